hex_readback: RTL and testbench
===============================

# hex_readback

Reads back the active-low 8-bit patterns driven onto the board's 7-segment digits (HEX0..HEX5) and decodes them into hexadecimal nibbles, so self-checking benches and on-chip monitors can confirm what the display logic is showing. It is the decoder counterpart to the switch-to-digit encoder logic. On a start request it snapshots all digit patterns, decodes one digit per clock, and then presents the results with a one-cycle done pulse.

## Interface
- NUM_DIGITS, default 6: number of 7-segment digits scanned (HEX0..HEX5).
- CLOCK_50  input  1: system clock; all logic is on the rising edge.
- reset  input  1: synchronous, active-high reset.
- start  input  1: scan request; sampled only in IDLE.
- hex_in  input  8*NUM_DIGITS: digit i pattern in bits [8i+7:8i]; bit 7 = DP, bit 0 = segment a; active-low (0 = lit).
- busy  output  1: high while a scan is in progress (SCAN or DONE).
- done  output  1: one-cycle pulse; results are valid from this cycle.
- value  output  4*NUM_DIGITS: decoded nibble of digit i in bits [4i+3:4i].
- invalid  output  NUM_DIGITS: bit i set if digit i's segment pattern is unrecognised.
- blank  output  NUM_DIGITS: bit i set if all seven segments of digit i are off.
- dp  output  NUM_DIGITS: bit i set if digit i's decimal point is lit (bit 7 = 0).

## Operation
- FSM states are IDLE, SCAN and DONE.
- IDLE, start=1: capture hex_in into the snapshot register, set idx=0, go to SCAN.
- SCAN: each cycle, decode snapshot digit idx into working registers, then idx++. When idx = NUM_DIGITS-1, copy the working registers to the outputs on the same edge and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Decode masks bit 7, and dp[i] = ~bit7.
- Bits [6:0] use this table (with DP off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Blank pattern: bits [6:0] = 7F gives blank=1, value=0, invalid=0.
- Any other pattern gives invalid=1, value=0, blank=0.
- start while busy is ignored and is not queued.
- Changes to hex_in after capture have no effect on the scan in progress.
- value, invalid, blank and dp hold their last results until the next scan completes; they never show partial results.
- reset in any state: state=IDLE, idx=0, and busy, done, value, invalid, blank and dp are all cleared to 0. A scan interrupted by reset never produces done.

## Timing
- start is sampled high at edge T.
- busy is high from after edge T through the DONE cycle.
- Digit i is decoded at edge T+1+i.
- Outputs and done update at edge T+NUM_DIGITS. done falls, and busy falls, at edge T+NUM_DIGITS+1.
- Latency from start to done is NUM_DIGITS cycles; with the default, done is high in the 6th cycle after start is sampled.
- Earliest next accepted start is at edge T+NUM_DIGITS+1, sampled in IDLE; back-to-back throughput is one scan per NUM_DIGITS+1 cycles.
- idx width is clog2(NUM_DIGITS), with a minimum of 1. idx never wraps, because the FSM leaves SCAN at NUM_DIGITS-1.

## Structure
- Shared package seg7_pkg holds:
  - 7-bit active-low constants SEG_0..SEG_F;
  - SEG_BLANK = 7'h7F;
  - the FSM state enum (IDLE, SCAN, DONE).
- The existing encoder logic adopts the same constants.
- Sub-module seg7_decode is purely combinational. Inputs: 7-bit pattern. Outputs: 4-bit value, invalid, blank. It has one instance, muxed by idx.

## Test plan
- Reset behaviour: assert reset for 2 cycles, then idle 5 cycles -> busy=0, done=0, value=0, invalid=0, blank=0, dp=0; done never pulses.
- Switch-style digits: hex_in digits 5..0 = F9,C0,F9,F9,C0,C0, start for 1 cycle -> done exactly 6 cycles later, value=24'h101100, invalid=0, blank=0, dp=0.
- Full table:
  - digits 0..5 = patterns for 0..5 -> value=24'h543210;
  - digits 0..5 = patterns for A..F -> value=24'hFEDCBA;
  - digits = 6,7,8,9,0,0 -> value=24'h009876.
- Flags: digit0=FF, digit1=00, digit2=AA, others C0 -> blank=6'b000001; dp=6'b000010 with value nibble1=8; invalid=6'b000100 with nibble2=0.
- Mid-scan activity: re-assert start and change hex_in to all 8E during cycles 2-4 of a scan -> exactly one done; results match the original snapshot; after done, a new start produces value=24'hFFFFFF.
- Reset mid-scan: apply reset at cycle 3 of a scan -> busy=0 and outputs=0 on the next cycle; no done pulse; a subsequent normal scan completes correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants and scan FSM states
package seg7_pkg;

  // Active-low segment patterns, bit 0 = segment a, DP excluded.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 7-segment pattern to hex nibble decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       invalid,
  output logic       blank
);

  always_comb begin
    value   = 4'h0;
    invalid = 1'b0;
    blank   = 1'b0;
    case (pattern)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_readback.sv
// rtl/hex_readback.sv - snapshots HEX digit patterns and decodes one digit per clock
module hex_readback
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*NUM_DIGITS-1:0] hex_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   invalid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   dp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx;
  logic [8*NUM_DIGITS-1:0] snapshot;
  logic [7:0]              cur_digit;
  logic [3:0]              dec_value;
  logic                    dec_invalid, dec_blank;

  logic [4*NUM_DIGITS-1:0] work_value, work_value_n;
  logic [NUM_DIGITS-1:0]   work_invalid, work_invalid_n;
  logic [NUM_DIGITS-1:0]   work_blank, work_blank_n;
  logic [NUM_DIGITS-1:0]   work_dp, work_dp_n;

  always_comb begin
    cur_digit = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_digit = snapshot[8*i +: 8];
    end
  end

  seg7_decode u_decode (
    .pattern (cur_digit[6:0]),
    .value   (dec_value),
    .invalid (dec_invalid),
    .blank   (dec_blank)
  );

  // Working set with the current digit merged in, so the final digit can be
  // published on the same edge it is decoded.
  always_comb begin
    work_value_n   = work_value;
    work_invalid_n = work_invalid;
    work_blank_n   = work_blank;
    work_dp_n      = work_dp;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        work_value_n[4*i +: 4] = dec_value;
        work_invalid_n[i]      = dec_invalid;
        work_blank_n[i]        = dec_blank;
        work_dp_n[i]           = ~cur_digit[7];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (idx == LAST_IDX) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      snapshot     <= '0;
      work_value   <= '0;
      work_invalid <= '0;
      work_blank   <= '0;
      work_dp      <= '0;
      value        <= '0;
      invalid      <= '0;
      blank        <= '0;
      dp           <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= hex_in;
            idx      <= '0;
          end
        end
        SCAN: begin
          work_value   <= work_value_n;
          work_invalid <= work_invalid_n;
          work_blank   <= work_blank_n;
          work_dp      <= work_dp_n;
          if (idx == LAST_IDX) begin
            value   <= work_value_n;
            invalid <= work_invalid_n;
            blank   <= work_blank_n;
            dp      <= work_dp_n;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_readback.sv
// tb/tb_hex_readback.sv - randomized self-checking bench for hex_readback
module tb_hex_readback;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [8*N-1:0] hex_in;
  logic          busy, done;
  logic [4*N-1:0] value;
  logic [N-1:0]  invalid, blank, dp;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [4*N-1:0] exp_value;
  logic [N-1:0]   exp_invalid, exp_blank, exp_dp;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  hex_readback #(.NUM_DIGITS(N)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .hex_in   (hex_in),
    .busy     (busy),
    .done     (done),
    .value    (value),
    .invalid  (invalid),
    .blank    (blank),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Table lookup per digit: DP forced off, blank recognised, anything else invalid.
  task automatic model(input logic [8*N-1:0] pat);
    logic [7:0] b;
    exp_value = '0; exp_invalid = '0; exp_blank = '0; exp_dp = '0;
    for (int i = 0; i < N; i++) begin
      b = pat[8*i +: 8];
      exp_dp[i] = (b[7] == 1'b0);
      b = b | 8'h80;
      if (b == 8'hFF) begin
        exp_blank[i] = 1'b1;
      end else begin
        exp_invalid[i] = 1'b1;
        for (int v = 0; v < 16; v++) begin
          if (seg_tab[v] == b) begin
            exp_invalid[i] = 1'b0;
            exp_value[4*i +: 4] = 4'(v);
          end
        end
      end
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check_results(input string name);
    checks++; if (value !== exp_value) begin errors++;
      $display("FAIL %s value: got %h expected %h", name, value, exp_value); end
    checks++; if (invalid !== exp_invalid) begin errors++;
      $display("FAIL %s invalid: got %b expected %b", name, invalid, exp_invalid); end
    checks++; if (blank !== exp_blank) begin errors++;
      $display("FAIL %s blank: got %b expected %b", name, blank, exp_blank); end
    checks++; if (dp !== exp_dp) begin errors++;
      $display("FAIL %s dp: got %b expected %b", name, dp, exp_dp); end
  endtask

  // One scan; disturb re-asserts start and rewrites hex_in mid-scan.
  task automatic scan_check(input string name, input logic [8*N-1:0] pat, input bit disturb);
    int lat;
    int d0;
    model(pat);
    hex_in = pat;
    start  = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, busy); end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (disturb && k >= 1 && k <= 3) begin
        start  = 1'b1;
        hex_in = {N{8'h8E}};
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin lat = k; break; end
    end
    start = 1'b0;
    checks++; if (lat != N) begin errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, N); end
    check_results(name);
    repeat (8) tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL %s busy_after_done: got %b expected 0", name, busy); end
    checks++; if (done_cnt - d0 != 1) begin errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0); end
    check_results({name, "_hold"});
  endtask

  task automatic test_reset;
    int d0;
    reset = 1'b1; start = 1'b0; hex_in = '0;
    repeat (2) tick();
    reset = 1'b0;
    d0 = done_cnt;
    repeat (5) tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset busy/done: got %b/%b expected 0/0", busy, done); end
    checks++; if (value !== '0 || invalid !== '0 || blank !== '0 || dp !== '0) begin errors++;
      $display("FAIL reset outputs: got %h %b %b %b expected zeros", value, invalid, blank, dp); end
    checks++; if (done_cnt != d0) begin errors++;
      $display("FAIL reset done_pulses: got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_switch;
    scan_check("switch", {8'hF9, 8'hC0, 8'hF9, 8'hF9, 8'hC0, 8'hC0}, 1'b0);
    checks++; if (value !== 24'h101100) begin errors++;
      $display("FAIL switch literal: got %h expected 101100", value); end
  endtask

  task automatic test_full_table;
    scan_check("tab_0_5", {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, 1'b0);
    checks++; if (value !== 24'h543210) begin errors++;
      $display("FAIL tab_0_5 literal: got %h expected 543210", value); end
    scan_check("tab_a_f", {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88}, 1'b0);
    checks++; if (value !== 24'hFEDCBA) begin errors++;
      $display("FAIL tab_a_f literal: got %h expected fedcba", value); end
    scan_check("tab_6_9", {8'hC0, 8'hC0, 8'h90, 8'h80, 8'hF8, 8'h82}, 1'b0);
    checks++; if (value !== 24'h009876) begin errors++;
      $display("FAIL tab_6_9 literal: got %h expected 009876", value); end
  endtask

  task automatic test_flags;
    scan_check("flags", {8'hC0, 8'hC0, 8'hC0, 8'hAA, 8'h00, 8'hFF}, 1'b0);
    checks++; if (blank !== 6'b000001 || dp !== 6'b000010 || invalid !== 6'b000100) begin errors++;
      $display("FAIL flags literal: got blank=%b dp=%b invalid=%b expected 000001 000010 000100",
               blank, dp, invalid); end
    checks++; if (value !== 24'h000080) begin errors++;
      $display("FAIL flags value_literal: got %h expected 000080", value); end
  endtask

  task automatic test_mid_scan;
    scan_check("mid_scan", {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, 1'b1);
    scan_check("after_mid", {N{8'h8E}}, 1'b0);
    checks++; if (value !== 24'hFFFFFF) begin errors++;
      $display("FAIL after_mid literal: got %h expected ffffff", value); end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    hex_in = {8'h86, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86};
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_mid busy/done: got %b/%b expected 0/0", busy, done); end
    checks++; if (value !== '0 || invalid !== '0 || blank !== '0 || dp !== '0) begin errors++;
      $display("FAIL reset_mid outputs: got %h %b %b %b expected zeros", value, invalid, blank, dp); end
    repeat (10) tick();
    checks++; if (done_cnt != d0) begin errors++;
      $display("FAIL reset_mid done_pulses: got %0d expected 0", done_cnt - d0); end
    scan_check("after_reset", {8'h83, 8'h90, 8'hF8, 8'h7F, 8'h12, 8'hC6}, 1'b0);
  endtask

  task automatic test_random;
    logic [8*N-1:0] pat;
    logic [7:0] b;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0, 1:    b = seg_tab[$urandom_range(0, 15)];
          2:       b = 8'hFF;
          default: b = 8'($urandom);
        endcase
        b[7] = 1'($urandom_range(0, 1));
        pat[8*i +: 8] = b;
      end
      scan_check("random", pat, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hex_in = '0;
    test_reset();
    test_switch();
    test_full_table();
    test_flags();
    test_mid_scan();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
